// File: rtl/lcd_pattern_timing_gen.sv
// lcd_pattern_timing_gen: LCD sync/DE timing generator with built-in test patterns
module lcd_pattern_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 210,
    parameter int H_SYNC    = 1,
    parameter int H_BP      = 45,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 22,
    parameter int V_SYNC    = 1,
    parameter int V_BP      = 22,
    parameter int COLOR_W   = 8,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int CHK_SHIFT = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iPIX_EN,
    input  logic [2:0]           iMODE,
    input  logic [3*COLOR_W-1:0] iSOLID_RGB,
    input  logic [11:0]          iCUR_X,
    input  logic [11:0]          iCUR_Y,
    input  logic                 iCUR_VALID,
    output logic [COLOR_W-1:0]   oLCD_R,
    output logic [COLOR_W-1:0]   oLCD_G,
    output logic [COLOR_W-1:0]   oLCD_B,
    output logic                 oHD,
    output logic                 oVD,
    output logic                 oDEN,
    output logic [11:0]          oX,
    output logic [11:0]          oY,
    output logic                 oFRAME_START
);
    localparam int CW3 = 3 * COLOR_W;
    localparam logic [11:0] H_LAST     = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [11:0] V_LAST     = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
    localparam logic [11:0] H_ACT_BEG  = 12'(H_SYNC + H_BP);
    localparam logic [11:0] V_ACT_BEG  = 12'(V_SYNC + V_BP);
    localparam logic [11:0] H_ACT_END  = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_ACT_END  = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] BAR_W      = 12'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);
    localparam logic        HS_ON      = (HS_POL != 0);
    localparam logic        VS_ON      = (VS_POL != 0);
    localparam logic [CW3-1:0] WHITE   = {CW3{1'b1}};
    localparam logic [CW3-1:0] BLACK   = {CW3{1'b0}};
    localparam logic [CW3-1:0] RED     = {{COLOR_W{1'b1}}, {2 * COLOR_W{1'b0}}};

    logic [11:0]    h_cnt, v_cnt, x, y, bar;
    logic [11:0]    cur_x, cur_y, cur_x_p, cur_y_p;
    logic [2:0]     mode_q, mode, bar_on;
    logic [CW3-1:0] solid_q, solid, rgb;
    logic           origin, h_sync, v_sync, den;

    // Decode the raster position into sync/active regions and the pattern colour
    always_comb begin
        origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
        mode   = origin ? iMODE : mode_q;
        solid  = origin ? iSOLID_RGB : solid_q;
        h_sync = h_cnt < H_SYNC_END;
        v_sync = v_cnt < V_SYNC_END;
        den    = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
                 (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        x      = h_cnt - H_ACT_BEG;
        y      = v_cnt - V_ACT_BEG;
        bar    = x / BAR_W;
        bar_on = (bar < 12'd8) ? {~bar[1], ~bar[2], ~bar[0]} : 3'b000;
        case (mode)
            3'd0:    rgb = {{COLOR_W{bar_on[2]}}, {COLOR_W{bar_on[1]}}, {COLOR_W{bar_on[0]}}};
            3'd1:    rgb = {3{x[COLOR_W-1:0]}};
            3'd2:    rgb = (x[CHK_SHIFT] ^ y[CHK_SHIFT]) ? BLACK : WHITE;
            3'd3:    rgb = solid;
            3'd4:    rgb = (x == cur_x || y == cur_y) ? WHITE : BLACK;
            default: rgb = RED;
        endcase
    end

    // Raster counters advance only on enabled pixel clocks
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (iPIX_EN) begin
            h_cnt <= (h_cnt == H_LAST) ? 12'd0 : h_cnt + 12'd1;
            if (h_cnt == H_LAST)
                v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end
    end

    // Cursor strobe is captured on any clock, enabled or not
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cur_x_p <= 12'd0;
            cur_y_p <= 12'd0;
        end else if (iCUR_VALID) begin
            cur_x_p <= iCUR_X;
            cur_y_p <= iCUR_Y;
        end
    end

    // Frame-wide settings change only at the top-left corner so a frame is never torn
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mode_q  <= 3'd0;
            solid_q <= BLACK;
            cur_x   <= 12'd0;
            cur_y   <= 12'd0;
        end else if (iPIX_EN && origin) begin
            mode_q  <= iMODE;
            solid_q <= iSOLID_RGB;
            cur_x   <= cur_x_p;
            cur_y   <= cur_y_p;
        end
    end

    // Output register: one enabled cycle behind the counters, blanked outside active video
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oHD                      <= ~HS_ON;
            oVD                      <= ~VS_ON;
            oDEN                     <= 1'b0;
            oX                       <= 12'd0;
            oY                       <= 12'd0;
            {oLCD_R, oLCD_G, oLCD_B} <= BLACK;
            oFRAME_START             <= 1'b0;
        end else if (iPIX_EN) begin
            oHD                      <= h_sync ? HS_ON : ~HS_ON;
            oVD                      <= v_sync ? VS_ON : ~VS_ON;
            oDEN                     <= den;
            oX                       <= den ? x : 12'd0;
            oY                       <= den ? y : 12'd0;
            {oLCD_R, oLCD_G, oLCD_B} <= den ? rgb : BLACK;
            oFRAME_START             <= origin;
        end
    end
endmodule

// File: doc/lcd_pattern_timing_gen.md
LCD_PATTERN_TIMING_GEN -- requirements
Module: lcd_pattern_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 SHALL have parameters H_FP 210, H_SYNC 1, H_BP 45: horizontal front porch, sync and back porch in pixel clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FP 22, V_SYNC 1, V_BP 22: vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-006 SHALL have parameters HS_POL 0 and VS_POL 0: asserted sync level, 0 = active-low.
REQ-007 SHALL have parameter CHK_SHIFT, default 4, checker square size log2.
REQ-008 SHALL have iCLK, input, 1 bit: single clock for all logic.
REQ-009 SHALL have iRST, input, 1 bit: reset, asynchronous, active-high.
REQ-010 SHALL have iPIX_EN, input, 1 bit: pixel-clock enable; counters and outputs advance only on enabled cycles.
REQ-011 SHALL have iMODE, input, 3 bits: pattern select.
REQ-012 SHALL have iSOLID_RGB, input, 3*COLOR_W bits: solid colour {R,G,B}.
REQ-013 SHALL have iCUR_X and iCUR_Y, inputs, 12 bits each, plus iCUR_VALID, input, 1 bit: cursor coordinate load strobe.
REQ-014 SHALL have outputs oLCD_R, oLCD_G, oLCD_B (COLOR_W bits each) and oHD, oVD, oDEN (1 bit each).
REQ-015 SHALL have outputs oX and oY (12 bits each, active pixel coordinate) and oFRAME_START (1 bit).

Function
REQ-016 SHALL count h_cnt 0..H_TOTAL-1, H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP, on each enabled cycle, wrapping to 0 and then incrementing v_cnt 0..V_TOTAL-1 (same sum for V), which also wraps.
REQ-017 SHALL define horizontal sync as h_cnt < H_SYNC and horizontal active as H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE; vertical regions are defined identically on v_cnt.
REQ-018 SHALL register all outputs, which SHALL lag the counters by exactly one enabled cycle; outputs hold when iPIX_EN=0.
REQ-019 SHALL drive oHD = HS_POL in the sync region and ~HS_POL otherwise; oVD is driven the same way using VS_POL.
REQ-020 SHALL drive oDEN=1 only when both horizontal and vertical are active; oX/oY are the active offsets then and hold 0 otherwise; RGB is all-zero whenever oDEN=0.
REQ-021 SHALL latch iMODE into mode_q only on the enabled cycle where h_cnt=0 and v_cnt=0; a mid-frame change has no visible effect until the next frame.
REQ-022 SHALL pulse oFRAME_START for one enabled cycle, aligned with the output of h_cnt=0,v_cnt=0.
REQ-023 Mode 0, colour bars: 8 bars of width H_ACTIVE/8 (integer division), in the order white, yellow, cyan, green, magenta, red, blue, black; remainder pixels SHALL be black.
REQ-024 Mode 1, grey ramp: R=G=B=x[COLOR_W-1:0], wrapping every 2^COLOR_W pixels.
REQ-025 Mode 2, checkerboard: white when x[CHK_SHIFT]^y[CHK_SHIFT]=0, else black.
REQ-026 Mode 3, solid colour: iSOLID_RGB, sampled together with iMODE at frame start.
REQ-027 Mode 4, crosshair: black background; white where x==cur_x or y==cur_y.
REQ-028 Modes 5-7 SHALL output a full-scale red frame (R all ones, G=B=0).
REQ-029 SHALL capture cur_x/cur_y on any cycle with iCUR_VALID=1, independent of iPIX_EN, but apply them only at the next frame start; out-of-range coordinates draw no line on that axis.
REQ-030 "White" means all channel bits 1; "black" means all 0.

Reset
REQ-031 SHALL, while iRST=1, asynchronously clear counters, mode_q (0), cursor (0) and solid colour (0), and drive oHD=~HS_POL, oVD=~VS_POL, oDEN=0, RGB=0, oX=oY=0, oFRAME_START=0.
REQ-032 SHALL, on iRST deassertion, emit the output of h_cnt=0,v_cnt=0 (oFRAME_START=1, sync asserted) on the first enabled cycle; reset mid-frame aborts the frame without glitching oDEN high.

Verification
REQ-033 Timing, params H 8/1/1/2, V 4/1/1/1, iPIX_EN=1: oHD low 1 clk every 12 clk; oVD low 12 clk every 84 clk; 32 oDEN-high clk per frame.
REQ-034 Mode 0 with H_ACTIVE=20: bars of 2 px each; x=16..19 black; x=0 RGB=FF/FF/FF; x=10 RGB=FF/00/00.
REQ-035 iMODE changed 0->2 mid-frame: current frame stays bars; next frame checkerboard, with x=16,y=0 black.
REQ-036 iPIX_EN toggled 1,0,1,0: all outputs change only after enabled cycles; the frame period doubles in iCLK cycles.
REQ-037 iCUR_VALID with X=5, Y=2 in mode 4: from the next frame, column 5 and row 2 are white, all else black; X=4095 gives only row 2.
REQ-038 iRST pulsed during the active region: outputs reach reset values immediately without waiting for iCLK; the first enabled cycle after release gives oFRAME_START=1.
